// File: rtl/gram_rd_arb.sv
// gram_rd_arb: two-requester read arbiter in front of a single-read-port RAM.
//
// Grants at most one read per cycle, round-robin on ties (requester 0 wins
// the first tie after reset). Each grant travels down an RD_LATENCY-deep
// {valid, id} pipeline so that the response strobe lines up with the RAM's
// read data.
//
// Parameters:
//   BUS_SIZE_ADDR - RAM address width
//   BUS_SIZE_DATA - RAM data width
//   RD_LATENCY    - RAM read latency in cycles (1 or 2)
//
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   reqN_valid/reqN_addr        - read request from requester N (N = 0, 1)
//   reqN_ready                  - request accepted this cycle (combinational)
//   rspN_valid/rspN_data        - one-cycle read response to requester N
//   ram_raddr                   - read address to the RAM
//   ram_dout                    - read data from the RAM
//   ram_we/ram_waddr            - RAM write-port snoop
//
// Optional build macro:
//   GRAM_RD_ARB_HAZARD_EN - withhold a grant whose address collides with a
//                           same-cycle RAM write. When undefined, the
//                           write-port snoop is ignored.

module gram_rd_arb #(
    parameter int unsigned BUS_SIZE_ADDR = 4,
    parameter int unsigned BUS_SIZE_DATA = 32,
    parameter int unsigned RD_LATENCY    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    input  logic [BUS_SIZE_ADDR-1:0] req0_addr,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [BUS_SIZE_ADDR-1:0] req1_addr,
    output logic                     req1_ready,
    output logic                     rsp0_valid,
    output logic [BUS_SIZE_DATA-1:0] rsp0_data,
    output logic                     rsp1_valid,
    output logic [BUS_SIZE_DATA-1:0] rsp1_data,
    output logic [BUS_SIZE_ADDR-1:0] ram_raddr,
    input  logic [BUS_SIZE_DATA-1:0] ram_dout,
    input  logic                     ram_we,
    input  logic [BUS_SIZE_ADDR-1:0] ram_waddr
);

    // 1 when requester 1 won the most recent grant.
    logic                     last_q;
    logic [BUS_SIZE_ADDR-1:0] raddr_q;
    logic [RD_LATENCY-1:0]    pipe_v_q;
    logic [RD_LATENCY-1:0]    pipe_id_q;

    logic hz0, hz1;
    logic elig0, elig1;
    logic gnt0, gnt1;

`ifdef GRAM_RD_ARB_HAZARD_EN
    assign hz0 = ram_we && (ram_waddr == req0_addr);
    assign hz1 = ram_we && (ram_waddr == req1_addr);
`else
    logic unused_snoop;
    assign unused_snoop = ram_we ^ (^ram_waddr);
    assign hz0 = 1'b0;
    assign hz1 = 1'b0;
`endif

    // rst_n gates eligibility so no ready is seen while reset is asserted.
    assign elig0 = rst_n && req0_valid && !hz0;
    assign elig1 = rst_n && req1_valid && !hz1;

    always_comb begin
        gnt0 = elig0 && (!elig1 || last_q);
        gnt1 = elig1 && (!elig0 || !last_q);
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        ram_raddr = raddr_q;
        if (gnt0) begin
            ram_raddr = req0_addr;
        end else if (gnt1) begin
            ram_raddr = req1_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b1;
            raddr_q   <= '0;
            pipe_v_q  <= '0;
            pipe_id_q <= '0;
        end else begin
            if (gnt0 || gnt1) begin
                last_q  <= gnt1;
                raddr_q <= ram_raddr;
            end
            pipe_v_q[0]  <= gnt0 || gnt1;
            pipe_id_q[0] <= gnt1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v_q[i]  <= pipe_v_q[i-1];
                pipe_id_q[i] <= pipe_id_q[i-1];
            end
        end
    end

    assign rsp0_valid = pipe_v_q[RD_LATENCY-1] && !pipe_id_q[RD_LATENCY-1];
    assign rsp1_valid = pipe_v_q[RD_LATENCY-1] &&  pipe_id_q[RD_LATENCY-1];
    assign rsp0_data  = ram_dout;
    assign rsp1_data  = ram_dout;

endmodule

// File: tb/tb_gram_rd_arb.sv
// tb_gram_rd_arb: directed + random bench for gram_rd_arb. Two instances
// share the request inputs: one with RD_LATENCY=2, one with RD_LATENCY=1.
// Expected responses are queued when a grant is predicted and checked when due.

module tb_gram_rd_arb;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic          ram_we = 1'b0;
    logic [AW-1:0] ram_waddr = '0;

    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_data, rsp1_data, ram_dout;
    logic [AW-1:0] ram_raddr;

    logic          b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
    logic [DW-1:0] b_rsp0_data, b_rsp1_data, b_ram_dout;
    logic [AW-1:0] b_ram_raddr;

    always #5 clk = ~clk;

    gram_rd_arb #(.BUS_SIZE_ADDR(AW), .BUS_SIZE_DATA(DW), .RD_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .ram_raddr(ram_raddr), .ram_dout(ram_dout),
        .ram_we(ram_we), .ram_waddr(ram_waddr)
    );

    gram_rd_arb #(.BUS_SIZE_ADDR(AW), .BUS_SIZE_DATA(DW), .RD_LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(b_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(b_req1_ready),
        .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data),
        .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data),
        .ram_raddr(b_ram_raddr), .ram_dout(b_ram_dout),
        .ram_we(ram_we), .ram_waddr(ram_waddr)
    );

    // RAM models: fixed contents, read latency 2 and 1.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] a_d1 = '0, a_d2 = '0, b_d1 = '0;
    always @(posedge clk) begin
        a_d1 <= mem[ram_raddr];
        a_d2 <= a_d1;
        b_d1 <= mem[b_ram_raddr];
    end
    assign ram_dout   = a_d2;
    assign b_ram_dout = b_d1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q2[$];
    exp_t q1[$];

    logic          m_last = 1'b1;
    logic [AW-1:0] m_raddr = '0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response scoreboards, sampled away from the active edge.
    always @(negedge clk) begin
        logic e0, e1;
        logic [DW-1:0] ed;
        e0 = 1'b0; e1 = 1'b0; ed = '0;
        if (q2.size() > 0 && q2[0].due == cyc) begin
            e0 = !q2[0].id; e1 = q2[0].id; ed = q2[0].data;
            void'(q2.pop_front());
        end
        chk("L2 rsp0_valid", {31'b0, rsp0_valid}, {31'b0, e0});
        chk("L2 rsp1_valid", {31'b0, rsp1_valid}, {31'b0, e1});
        if (e0) chk("L2 rsp0_data", rsp0_data, ed);
        if (e1) chk("L2 rsp1_data", rsp1_data, ed);
    end

    always @(negedge clk) begin
        logic e0, e1;
        logic [DW-1:0] ed;
        e0 = 1'b0; e1 = 1'b0; ed = '0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e0 = !q1[0].id; e1 = q1[0].id; ed = q1[0].data;
            void'(q1.pop_front());
        end
        chk("L1 rsp0_valid", {31'b0, b_rsp0_valid}, {31'b0, e0});
        chk("L1 rsp1_valid", {31'b0, b_rsp1_valid}, {31'b0, e1});
        if (e0) chk("L1 rsp0_data", b_rsp0_data, ed);
        if (e1) chk("L1 rsp1_data", b_rsp1_data, ed);
    end

    // One cycle of stimulus; entered and left just after a rising edge.
    task automatic step(input logic v0, input logic [AW-1:0] a0,
                        input logic v1, input logic [AW-1:0] a1,
                        input logic we, input logic [AW-1:0] wa);
        logic h0, h1, e0, e1, g0, g1;
        logic [AW-1:0] ea;
        req0_valid = v0; req0_addr = a0;
        req1_valid = v1; req1_addr = a1;
        ram_we = we;     ram_waddr = wa;
        h0 = 1'b0; h1 = 1'b0;
`ifdef GRAM_RD_ARB_HAZARD_EN
        h0 = we && (wa == a0);
        h1 = we && (wa == a1);
`endif
        e0 = v0 && !h0;
        e1 = v1 && !h1;
        g0 = e0 && (!e1 || m_last);
        g1 = e1 && (!e0 || !m_last);
        ea = g0 ? a0 : (g1 ? a1 : m_raddr);
        @(negedge clk);
        chk("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
        chk("req1_ready", {31'b0, req1_ready}, {31'b0, g1});
        chk("ram_raddr", {28'b0, ram_raddr}, {28'b0, ea});
        chk("L1 req0_ready", {31'b0, b_req0_ready}, {31'b0, g0});
        chk("L1 ram_raddr", {28'b0, b_ram_raddr}, {28'b0, ea});
        if (g0 || g1) begin
            q2.push_back('{cyc + 2, g1, mem[ea]});
            q1.push_back('{cyc + 1, g1, mem[ea]});
            m_last  = g1;
            m_raddr = ea;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset for n cycles with both requesters asking; in-flight reads are dropped.
    task automatic reset_phase(input int n);
        rst_n = 1'b0;
        q2.delete();
        q1.delete();
        m_last  = 1'b1;
        m_raddr = '0;
        req0_valid = 1'b1; req0_addr = 4'd1;
        req1_valid = 1'b1; req1_addr = 4'd2;
        ram_we = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("rst req0_ready", {31'b0, req0_ready}, 32'd0);
            chk("rst req1_ready", {31'b0, req1_ready}, 32'd0);
            chk("rst ram_raddr", {28'b0, ram_raddr}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] ra0, ra1, rwa;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        reset_phase(3);

        // First tie goes to requester 0, then alternate.
        repeat (4) step(1'b1, 4'd3, 1'b1, 4'd7, 1'b0, 4'd0);
        // Idle: address held, responses drain.
        repeat (3) step(1'b0, 4'd9, 1'b0, 4'd10, 1'b0, 4'd0);

        // Single requester, back-to-back.
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b1, 4'(i), 1'b0, 4'd0);
        repeat (3) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);

        // Write collision on requester 0's address.
        step(1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 4'd5);
        step(1'b1, 4'd5, 1'b1, 4'd6, 1'b0, 4'd0);
        repeat (3) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);

        // Reset one cycle after a grant: that read must never respond.
        step(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        reset_phase(2);
        repeat (4) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        // Tie right after reset again favours requester 0.
        step(1'b1, 4'd11, 1'b1, 4'd12, 1'b0, 4'd0);

        // Random traffic with frequent write collisions.
        for (int i = 0; i < 30; i++) begin
            ra0 = 4'($urandom_range(0, 15));
            ra1 = 4'($urandom_range(0, 15));
            rwa = ($urandom_range(0, 1) == 0) ? ra0 : ra1;
            step(1'($urandom_range(0, 1)), ra0, 1'($urandom_range(0, 1)), ra1,
                 ($urandom_range(0, 2) == 0), rwa);
        end
        repeat (4) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
